// File: rtl/param_loader.sv
`default_nettype none
// ============================================================================
// Module   : param_loader
// Brief    : Unpacks host command/data words into write ports on the image,
//            conv, dense-weight and dense-bias RAMs with auto-increment address.
//            Optional macro LOADER_CHECKSUM_EN adds a 16-bit written-byte sum.
// Revision : 1.0 - initial release
// ============================================================================
module param_loader #(
    parameter int IMG_AW = 10,
    parameter int PRM_AW = 15,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_data,
    input  logic              data_valid,
    input  logic [31:0]       data_word,
    output logic              data_ready,
    output logic [3:0]        wren_image,
    output logic [31:0]       image_data,
    output logic [IMG_AW-1:0] image_addr,
    output logic              wren_conv,
    output logic              wren_dense,
    output logic              wren_denseb,
    output logic [7:0]        prm_data,
    output logic [PRM_AW-1:0] prm_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       checksum
);

    localparam logic [1:0] c_TGT_IMG   = 2'd0;
    localparam logic [1:0] c_TGT_CONV  = 2'd1;
    localparam logic [1:0] c_TGT_DENSE = 2'd2;
    localparam logic [1:0] c_TGT_BIAS  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UNPACK = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         tgt_q;
    logic [PRM_AW-1:0]  addr_q;
    logic [CNT_W-1:0]   rem_q;
    logic [31:0]        word_q;
    logic [1:0]         idx_q;

    logic               data_ready_q;
    logic [3:0]         wren_image_q;
    logic [31:0]        image_data_q;
    logic [IMG_AW-1:0]  image_addr_q;
    logic               wren_conv_q;
    logic               wren_dense_q;
    logic               wren_denseb_q;
    logic [7:0]         prm_data_q;
    logic [PRM_AW-1:0]  prm_addr_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               w_cmd_accept;
    logic               w_cnt_zero;
    logic [7:0]         w_byte;

    assign w_cmd_accept = (state_q == S_IDLE) && cmd_valid;
    assign w_cnt_zero   = (cmd_data[31:17] == 15'd0);
    assign w_byte       = word_q[8*idx_q +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tgt_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            word_q        <= '0;
            idx_q         <= '0;
            data_ready_q  <= 1'b0;
            wren_image_q  <= '0;
            image_data_q  <= '0;
            image_addr_q  <= '0;
            wren_conv_q   <= 1'b0;
            wren_dense_q  <= 1'b0;
            wren_denseb_q <= 1'b0;
            prm_data_q    <= '0;
            prm_addr_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            wren_image_q  <= '0;
            wren_conv_q   <= 1'b0;
            wren_dense_q  <= 1'b0;
            wren_denseb_q <= 1'b0;

            // A data beat arriving alongside an accepted command still counts as an error
            if (w_cmd_accept)
                err_q <= data_valid;
            else if (cmd_valid || (data_valid && !data_ready_q))
                err_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        tgt_q  <= cmd_data[1:0];
                        addr_q <= (cmd_data[1:0] == c_TGT_IMG) ? PRM_AW'(cmd_data[IMG_AW+1:2])
                                                               : PRM_AW'(cmd_data[16:2]);
                        rem_q  <= CNT_W'(cmd_data[31:17]);
                        if (w_cnt_zero) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q      <= S_LOAD;
                            busy_q       <= 1'b1;
                            data_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (data_valid) begin
                        if (tgt_q == c_TGT_IMG) begin
                            wren_image_q <= 4'hF;
                            image_data_q <= data_word;
                            image_addr_q <= addr_q[IMG_AW-1:0];
                            addr_q       <= addr_q + PRM_AW'(1);
                            rem_q        <= rem_q - CNT_W'(1);
                            if (rem_q == CNT_W'(1)) begin
                                state_q      <= S_FIN;
                                data_ready_q <= 1'b0;
                            end
                        end else begin
                            word_q       <= data_word;
                            idx_q        <= 2'd0;
                            state_q      <= S_UNPACK;
                            data_ready_q <= 1'b0;
                        end
                    end
                end
                S_UNPACK: begin
                    wren_conv_q   <= (tgt_q == c_TGT_CONV);
                    wren_dense_q  <= (tgt_q == c_TGT_DENSE);
                    wren_denseb_q <= (tgt_q == c_TGT_BIAS);
                    prm_data_q    <= w_byte;
                    prm_addr_q    <= addr_q;
                    addr_q        <= addr_q + PRM_AW'(1);
                    rem_q         <= rem_q - CNT_W'(1);
                    idx_q         <= idx_q + 2'd1;
                    // Leftover bytes of a short final word are simply never emitted
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= S_FIN;
                    end else if (idx_q == 2'd3) begin
                        state_q      <= S_LOAD;
                        data_ready_q <= 1'b1;
                    end
                end
                default: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] cks_q;
    logic [15:0] cks_d;

    always_comb begin
        cks_d = cks_q;
        if (w_cmd_accept)
            cks_d = '0;
        else if (state_q == S_LOAD && data_valid && tgt_q == c_TGT_IMG)
            cks_d = cks_q + 16'(data_word[7:0]) + 16'(data_word[15:8])
                          + 16'(data_word[23:16]) + 16'(data_word[31:24]);
        else if (state_q == S_UNPACK)
            cks_d = cks_q + 16'(w_byte);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cks_q <= '0;
        else
            cks_q <= cks_d;
    end

    assign checksum = cks_q;
`else
    assign checksum = 16'h0000;
`endif

    assign data_ready  = data_ready_q;
    assign wren_image  = wren_image_q;
    assign image_data  = image_data_q;
    assign image_addr  = image_addr_q;
    assign wren_conv   = wren_conv_q;
    assign wren_dense  = wren_dense_q;
    assign wren_denseb = wren_denseb_q;
    assign prm_data    = prm_data_q;
    assign prm_addr    = prm_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_param_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_loader
// Brief    : Self-checking bench for param_loader against a schedule-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, data_valid;
    logic [31:0] cmd_data, data_word;
    logic        data_ready, wren_conv, wren_dense, wren_denseb, busy, done, err;
    logic [3:0]  wren_image;
    logic [31:0] image_data;
    logic [9:0]  image_addr;
    logic [7:0]  prm_data;
    logic [14:0] prm_addr;
    logic [15:0] checksum;

    param_loader #(.IMG_AW(10), .PRM_AW(15), .CNT_W(15)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .data_valid(data_valid), .data_word(data_word), .data_ready(data_ready),
        .wren_image(wren_image), .image_data(image_data), .image_addr(image_addr),
        .wren_conv(wren_conv), .wren_dense(wren_dense), .wren_denseb(wren_denseb),
        .prm_data(prm_data), .prm_addr(prm_addr),
        .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    localparam int BIG = 32'h7fffffff;

    // Model: command bookkeeping in absolute cycle numbers plus a write schedule
    int          cyc;
    int          ready_from, idle_at, busy_from, busy_to, done_at, cov_rem;
    logic [1:0]  tgt_m;
    logic [14:0] addr_m;
    logic        err_m;
    logic [15:0] cks_m;

    bit          s_wimg[16];
    logic [9:0]  s_iaddr[16];
    logic [31:0] s_idata[16];
    logic [1:0]  s_wsel[16];
    logic [7:0]  s_pdata[16];
    logic [14:0] s_paddr[16];
    int          s_cadd[16];
    bit          s_cclr[16];

    // Expected outputs for the current cycle
    bit          e_all0, e_ready, e_busy, e_done, e_err, e_wimg;
    logic [9:0]  e_iaddr;
    logic [31:0] e_idata;
    logic [1:0]  e_wsel;
    logic [7:0]  e_pdata;
    logic [14:0] e_paddr;
    logic [15:0] e_cks;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_slot(input int s);
        s_wimg[s] = 0; s_iaddr[s] = '0; s_idata[s] = '0; s_wsel[s] = 2'd0;
        s_pdata[s] = '0; s_paddr[s] = '0; s_cadd[s] = 0; s_cclr[s] = 0;
    endtask

    task automatic model_reset();
        ready_from = 0; idle_at = 0; busy_from = 0; busy_to = 0; done_at = -1; cov_rem = 0;
        tgt_m = 2'd0; addr_m = '0; err_m = 1'b0; cks_m = '0;
        for (int i = 0; i < 16; i++) clear_slot(i);
        e_all0 = 1; e_ready = 0; e_busy = 0; e_done = 0; e_err = 0; e_wimg = 0;
        e_iaddr = '0; e_idata = '0; e_wsel = 2'd0; e_pdata = '0; e_paddr = '0; e_cks = '0;
    endtask

    task automatic finish_at(input int t);
        idle_at = t; busy_to = t; done_at = t;
    endtask

    // Consume this cycle's inputs, then produce the expectation for the next cycle
    task automatic model_step();
        int c, n1, n, s;
        bit rdy, idl, acc;
        int cnt;
        if (reset) begin
            model_reset();
            cyc++;
            return;
        end
        c   = cyc;
        n1  = c + 1;
        rdy = (c >= ready_from) && (cov_rem > 0);
        idl = (c >= idle_at);
        acc = cmd_valid && idl;
        if (acc) err_m = 1'b0;
        if ((cmd_valid && !idl) || (data_valid && !rdy)) err_m = 1'b1;
        if (acc) begin
            cnt   = int'(cmd_data[31:17]);
            tgt_m = cmd_data[1:0];
            addr_m = (tgt_m == 2'd0) ? {5'd0, cmd_data[11:2]} : cmd_data[16:2];
            s_cclr[n1 % 16] = 1;
            if (cnt == 0) begin
                idle_at = c + 2;
                done_at = c + 2;
            end else begin
                cov_rem = cnt; ready_from = n1; busy_from = n1; busy_to = BIG; idle_at = BIG;
            end
        end
        if (data_valid && rdy) begin
            if (tgt_m == 2'd0) begin
                s = n1 % 16;
                s_wimg[s]  = 1;
                s_iaddr[s] = addr_m[9:0];
                s_idata[s] = data_word;
                s_cadd[s]  = data_word[7:0] + data_word[15:8] + data_word[23:16] + data_word[31:24];
                addr_m = (addr_m + 15'd1) & 15'h03FF;
                cov_rem--;
                if (cov_rem == 0) finish_at(c + 2);
            end else begin
                n = (cov_rem < 4) ? cov_rem : 4;
                for (int k = 0; k < n; k++) begin
                    s = (c + 2 + k) % 16;
                    s_wsel[s]  = tgt_m;
                    s_pdata[s] = data_word[8*k +: 8];
                    s_paddr[s] = addr_m;
                    s_cadd[s]  = data_word[8*k +: 8];
                    addr_m = addr_m + 15'd1;
                end
                cov_rem -= n;
                if (cov_rem > 0) ready_from = c + 5;
                else finish_at(c + 2 + n);
            end
        end
        cyc = n1;
        s = n1 % 16;
        e_all0  = 0;
        e_ready = (n1 >= ready_from) && (cov_rem > 0);
        e_busy  = (n1 >= busy_from) && (n1 < busy_to);
        e_done  = (n1 == done_at);
        e_err   = err_m;
        e_wimg  = s_wimg[s];
        e_iaddr = s_iaddr[s];
        e_idata = s_idata[s];
        e_wsel  = s_wsel[s];
        e_pdata = s_pdata[s];
        e_paddr = s_paddr[s];
        if (s_cclr[s]) cks_m = '0;
        cks_m = cks_m + s_cadd[s][15:0];
`ifdef LOADER_CHECKSUM_EN
        e_cks = cks_m;
`else
        e_cks = '0;
`endif
        clear_slot(s);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            if (e_all0) begin
                chk("rst_outputs", {wren_image, wren_conv, wren_dense, wren_denseb, data_ready,
                                    busy, done, err}, 32'h0);
                chk("rst_image_data", image_data, 32'h0);
                chk("rst_addr", {image_addr, prm_addr}, 32'h0);
                chk("rst_prm_data", prm_data, 32'h0);
                chk("rst_checksum", checksum, 32'h0);
            end else begin
                chk("data_ready", data_ready, e_ready);
                chk("busy", busy, e_busy);
                chk("done", done, e_done);
                chk("err", err, e_err);
                chk("wren_image", wren_image, e_wimg ? 4'hF : 4'h0);
                chk("wren_conv", wren_conv, e_wsel == 2'd1);
                chk("wren_dense", wren_dense, e_wsel == 2'd2);
                chk("wren_denseb", wren_denseb, e_wsel == 2'd3);
                chk("checksum", checksum, e_cks);
                if (e_wimg) begin
                    chk("image_addr", image_addr, e_iaddr);
                    chk("image_data", image_data, e_idata);
                end
                if (e_wsel != 2'd0) begin
                    chk("prm_addr", prm_addr, e_paddr);
                    chk("prm_data", prm_data, e_pdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [1:0] tgt, input logic [14:0] base, input logic [14:0] cnt);
        cmd_valid = 1'b1;
        cmd_data  = {cnt, base, tgt};
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        data_valid = 1'b1;
        data_word  = w;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; data_valid = 1'b0; cmd_data = '0; data_word = '0;
        cyc = 0;
        #2 reset = 1'b1;
        model_reset();
        chk_on = 1'b1;
        idle(2);
        chk("lit_reset_busy_done_err", {busy, done, err, data_ready}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Image load with address wrap
        send_cmd(2'd0, 15'h03FE, 15'd3);
        chk("lit_img_ready", data_ready, 1'b1);
        send_word(32'h04030201);
        chk("lit_img_addr0", image_addr, 10'h3FE);
        chk("lit_img_data0", image_data, 32'h04030201);
        send_word(32'h08070605);
        send_word(32'h0C0B0A09);
        chk("lit_img_addr2", image_addr, 10'h000);
        idle(1);
        chk("lit_img_done", done, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        chk("lit_img_checksum", checksum, 16'h004E);
`endif
        idle(2);

        // Conv partial final word
        send_cmd(2'd1, 15'h0010, 15'd6);
        send_word(32'hDDCCBBAA);
        chk("lit_conv_ready_low", data_ready, 1'b0);
        tick();
        chk("lit_conv_b0", {wren_conv, prm_addr, prm_data}, {1'b1, 15'h0010, 8'hAA});
        idle(3);
        send_word(32'h44332211);
        idle(2);
        chk("lit_conv_b5", {wren_conv, prm_addr, prm_data}, {1'b1, 15'h0015, 8'h22});
        tick();
        chk("lit_conv_no_b6", wren_conv, 1'b0);
        idle(3);

        // Bias with prm address wrap
        send_cmd(2'd3, 15'h7FFF, 15'd2);
        send_word(32'h0000BEEF);
        tick();
        chk("lit_bias_b0", {wren_denseb, prm_addr, prm_data}, {1'b1, 15'h7FFF, 8'hEF});
        tick();
        chk("lit_bias_b1", {wren_denseb, prm_addr, prm_data}, {1'b1, 15'h0000, 8'hBE});
        idle(3);

        // Protocol errors
        send_word(32'h12345678);
        chk("lit_err_idle_data", err, 1'b1);
        send_cmd(2'd2, 15'h0100, 15'd4);
        chk("lit_err_cleared", err, 1'b0);
        send_word(32'hA1B2C3D4);
        send_cmd(2'd1, 15'h0000, 15'd5);
        chk("lit_err_cmd_busy", err, 1'b1);
        idle(6);
        send_cmd(2'd1, 15'h0000, 15'd0);
        chk("lit_err_zero_cmd_clear", err, 1'b0);
        tick();
        chk("lit_zero_done", {done, busy}, 2'b10);
        idle(2);

        // Reset in the middle of a dense load
        send_cmd(2'd2, 15'h0020, 15'd8);
        send_word(32'h55667788);
        idle(2);
        reset = 1'b1;
        model_reset();
        #1;
        chk("lit_midreset_outputs", {wren_image, wren_conv, wren_dense, wren_denseb, data_ready,
                                     busy, done, err}, 32'h0);
        chk("lit_midreset_prm", {prm_addr, prm_data}, 32'h0);
        idle(2);
        reset = 1'b0;
        idle(8);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            logic [14:0] cnt, base;
            int r;
            r = $urandom_range(0, 3);
            cnt  = (r == 0) ? 15'($urandom_range(0, 2)) : 15'($urandom_range(1, 14));
            r = $urandom_range(0, 3);
            base = (r == 0) ? 15'h7FFC + 15'($urandom_range(0, 3))
                 : (r == 1) ? 15'h03FC + 15'($urandom_range(0, 3)) : 15'($urandom);
            cmd_valid  = ($urandom_range(0, 24) == 0);
            cmd_data   = {cnt, base, 2'($urandom_range(0, 3))};
            data_valid = e_ready ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 4);
            data_word  = $urandom;
            tick();
        end
        cmd_valid = 1'b0; data_valid = 1'b0;
        idle(10);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_loader.md
Name: param_loader

Overview:
- Host-side load engine between the Avalon register block and the accelerator RAM bank.
- Accepts a load command, then a stream of 32-bit host data words.
- Unpacks each word and drives byte-wide write ports on the image, conv, dense-weight and dense-bias RAMs, auto-incrementing the address.
- Reports busy/done/error status back to the register block.

Parameters:
- IMG_AW, 10, image RAM address width (one address per 4-bank word).
- PRM_AW, 15, conv/dense/bias RAM address width.
- CNT_W, 15, command write-count width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  one-cycle pulse: cmd_data holds a new command
- cmd_data  in  32  [1:0] target (0 image, 1 conv, 2 dense, 3 bias); [16:2] base address; [31:17] write count
- data_valid  in  1  one-cycle pulse: data_word is valid
- data_word  in  32  host payload; byte0 = [7:0]
- data_ready  out  1  engine will accept data_word this cycle
- wren_image  out  4  per-bank write enable, image banks 0..3
- image_data  out  32  bank n gets [8n+7:8n]
- image_addr  out  IMG_AW  image write address
- wren_conv, wren_dense, wren_denseb  out  1 each  byte write enables
- prm_data  out  8  shared byte for conv/dense/bias
- prm_addr  out  PRM_AW  shared write address
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  sticky protocol error
- checksum  out  16  see Optional Feature

Behaviour:
- All outputs registered. Reset clears every output to 0, FSM to IDLE, and all internal counters to 0.
- FSM states: IDLE, LOAD, UNPACK, FIN.
- IDLE: data_ready=0.
  - cmd_valid with count!=0: latch target, addr=base (truncated to IMG_AW for image), remaining=count. Next cycle: LOAD, busy=1, err=0.
  - cmd_valid with count==0: go to FIN with no writes; err cleared.
- LOAD: data_ready=1.
  - data_valid, image target: next cycle wren_image=4'hF, image_data=data_word, image_addr=addr. Then addr++, remaining--. If remaining reaches 0 go to FIN, else stay in LOAD.
  - data_valid, other target: latch word, byte index=0, go to UNPACK. data_ready=0 from the following cycle.
- UNPACK: one byte per cycle, byte0 first.
  - Asserts exactly one of wren_conv/dense/denseb for one cycle, with prm_data=byte and prm_addr=addr; then addr++, remaining--.
  - After byte3, or when remaining hits 0: go to LOAD, or to FIN if remaining==0.
  - Unused bytes of the final word are discarded without writing.
- Throughput: image target accepts 1 word/cycle. Serial targets take 4 cycles per word plus 1 cycle for acceptance.
- FIN: done=1 for one cycle, busy=0, return to IDLE. Write enables are 0 in FIN.
- Address wrap: image_addr wraps modulo 2^IMG_AW; prm_addr wraps modulo 2^PRM_AW. No error is raised on wrap.
- cmd_valid while busy: command ignored, err set.
- data_valid while data_ready=0 (IDLE, UNPACK, FIN): word dropped, err set. This includes a simultaneous cmd_valid+data_valid in IDLE.
- err stays set until the next accepted command.
- At most one write enable output is high in any cycle, counting wren_image as a group.
- Reset asserted mid-command: immediate abort; no further writes after release.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: checksum is a 16-bit wrapping sum of every byte actually written.
  - Image target contributes all 4 bytes per write.
  - Cleared on command acceptance; holds its value after FIN until the next command.
- Undefined: checksum tied to 0 and no adder logic is built.

Test Plan:
- Image load: cmd target=0, base=0x3FE, count=3; words 0x04030201, 0x08070605, 0x0C0B0A09 back-to-back -> three cycles of wren_image=F at addresses 0x3FE, 0x3FF, 0x000 with those words; done pulses once; checksum=0x004E when enabled.
- Conv partial word: cmd target=1, base=0x10, count=6; words 0xDDCCBBAA, 0x44332211 -> wren_conv writes AA,BB,CC,DD,11,22 at 0x10..0x15; bytes 0x33/0x44 never written; data_ready low during unpack.
- Bias wrap: cmd target=3, base=0x7FFF, count=2; word 0x0000BEEF -> wren_denseb writes EF@0x7FFF, BE@0x0000; wren_conv/wren_dense stay 0.
- Protocol errors: data_valid in IDLE -> err=1, no writes; cmd_valid during active load -> err stays 1, original load completes; next command clears err.
- Count zero: cmd count=0 -> done pulse within 2 cycles, no write enables, busy never high.
- Reset mid-load: dense load count=8, assert reset after 2nd byte -> all outputs 0 immediately; after release no writes and busy=0.
